commit_wb_receiver: RTL and testbench

//  Commit-side receiver of the writeback->commit channel bundle (per-channel enable/valid/rob_id/exception/branch result).

---
 rtl/commit_wb_receiver_pkg.sv | 28 ++
 rtl/rob_complete_entry.sv | 53 +++++
 rtl/commit_wb_receiver.sv | 163 ++++++++++++++++
 tb/tb_commit_wb_receiver.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_wb_receiver_pkg.sv
// Shared types and widths for the writeback->commit receiver and its completion table.
package commit_wb_receiver_pkg;

    localparam int unsigned CH_NUM   = 4;
    localparam int unsigned ROB_SIZE = 64;
    localparam int unsigned ROB_ID_W = 6;
    localparam int unsigned ALLOC_W  = 2;
    localparam int unsigned COMMIT_W = 2;
    localparam int unsigned EXC_ID_W = 5;
    localparam int unsigned DATA_W   = 32;

    typedef logic [ROB_ID_W-1:0] rob_id_t;
    typedef logic [EXC_ID_W-1:0] exc_id_t;

    typedef struct packed {
        logic              has_exc;
        exc_id_t           exc_id;
        logic [DATA_W-1:0] exc_value;
        logic              bru_jump;
        logic [DATA_W-1:0] bru_next_pc;
    } wb_payload_t;

    typedef struct packed {
        logic        finished;
        wb_payload_t payload;
    } commit_slot_status_t;

endpackage

// File: rtl/rob_complete_entry.sv
// One ROB completion-table entry: allocated/finished flags plus the captured writeback payload.
// Update priority: flush > retire > alloc > complete.
module rob_complete_entry
    import commit_wb_receiver_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        retire,
    input  logic        alloc,
    input  logic        complete,
    input  wb_payload_t payload_in,
    output logic        allocated,
    output logic        finished,
    output logic        finished_next,
    output wb_payload_t payload_next
);

    logic        allocated_next;
    wb_payload_t payload;

    always_comb begin
        allocated_next = allocated;
        finished_next  = finished;
        payload_next   = payload;
        if (flush || retire) begin
            allocated_next = 1'b0;
            finished_next  = 1'b0;
        end else if (alloc) begin
            allocated_next = 1'b1;
            finished_next  = 1'b0;
        end else if (complete && allocated) begin
            finished_next = 1'b1;
            payload_next  = payload_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            allocated <= 1'b0;
            finished  <= 1'b0;
        end else begin
            allocated <= allocated_next;
            finished  <= finished_next;
        end
    end

    // Payload is only observed while finished, so it carries no reset.
    always_ff @(posedge clk) begin
        payload <= payload_next;
    end

endmodule

// File: rtl/commit_wb_receiver.sv
// Commit-side receiver of the writeback->commit bundle: per-ROB-entry completion table with
// registered status for the oldest COMMIT_W entries, in-flight counter and sticky protocol error.
module commit_wb_receiver
    import commit_wb_receiver_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         wb_we,
    input  logic                         wb_flush,
    input  logic [CH_NUM-1:0]            wb_enable,
    input  logic [CH_NUM-1:0]            wb_valid,
    input  logic [CH_NUM*ROB_ID_W-1:0]   wb_rob_id,
    input  logic [CH_NUM-1:0]            wb_has_exc,
    input  logic [CH_NUM*EXC_ID_W-1:0]   wb_exc_id,
    input  logic [CH_NUM*DATA_W-1:0]     wb_exc_value,
    input  logic [CH_NUM-1:0]            wb_bru_jump,
    input  logic [CH_NUM*DATA_W-1:0]     wb_bru_next_pc,
    input  logic [ALLOC_W-1:0]           alloc_valid,
    input  logic [ALLOC_W*ROB_ID_W-1:0]  alloc_id,
    input  logic [ROB_ID_W-1:0]          head_id,
    input  logic [COMMIT_W-1:0]          retire_valid,
    output logic [COMMIT_W-1:0]          slot_finished,
    output logic [COMMIT_W-1:0]          slot_has_exc,
    output logic [COMMIT_W*EXC_ID_W-1:0] slot_exc_id,
    output logic [COMMIT_W*DATA_W-1:0]   slot_exc_value,
    output logic [COMMIT_W-1:0]          slot_bru_jump,
    output logic [COMMIT_W*DATA_W-1:0]   slot_bru_next_pc,
    output logic [ROB_ID_W:0]            inflight_cnt,
    output logic                         proto_err
);

    localparam int unsigned CntW = ROB_ID_W + 2;
    typedef logic [CntW-1:0] cnt_sum_t;

    logic [CH_NUM-1:0]   ch_acc;
    rob_id_t             ch_id [CH_NUM];
    wb_payload_t         ch_pl [CH_NUM];
    rob_id_t             al_id [ALLOC_W];

    logic [ROB_SIZE-1:0] alloc_hit, retire_hit, comp_hit;
    logic [ROB_SIZE-1:0] alloc_q, fin_q, fin_d;
    wb_payload_t         comp_pl [ROB_SIZE];
    wb_payload_t         pl_d    [ROB_SIZE];

    rob_id_t             next_head;
    cnt_sum_t            cnt_sum;
    logic [ROB_ID_W:0]   cnt_q;
    logic                err_d, err_q;
    commit_slot_status_t [COMMIT_W-1:0] slot_d, slot_q;

    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            ch_acc[i]               = wb_we & wb_enable[i] & wb_valid[i];
            ch_id[i]                = wb_rob_id[i*ROB_ID_W +: ROB_ID_W];
            ch_pl[i].has_exc        = wb_has_exc[i];
            ch_pl[i].exc_id         = wb_exc_id[i*EXC_ID_W +: EXC_ID_W];
            ch_pl[i].exc_value      = wb_exc_value[i*DATA_W +: DATA_W];
            ch_pl[i].bru_jump       = wb_bru_jump[i];
            ch_pl[i].bru_next_pc    = wb_bru_next_pc[i*DATA_W +: DATA_W];
        end
        for (int a = 0; a < ALLOC_W; a++) begin
            al_id[a] = alloc_id[a*ROB_ID_W +: ROB_ID_W];
        end
    end

    always_comb begin
        alloc_hit  = '0;
        retire_hit = '0;
        comp_hit   = '0;
        for (int e = 0; e < ROB_SIZE; e++) begin
            comp_pl[e] = '0;
            for (int a = 0; a < ALLOC_W; a++) begin
                if (alloc_valid[a] && al_id[a] == rob_id_t'(e)) alloc_hit[e] = 1'b1;
            end
            // Scan high to low so the lowest matching channel's payload is kept.
            for (int i = CH_NUM - 1; i >= 0; i--) begin
                if (ch_acc[i] && ch_id[i] == rob_id_t'(e)) begin
                    comp_hit[e] = 1'b1;
                    comp_pl[e]  = ch_pl[i];
                end
            end
        end
        for (int k = 0; k < COMMIT_W; k++) begin
            if (retire_valid[k]) retire_hit[head_id + rob_id_t'(k)] = 1'b1;
        end
    end

    for (genvar e = 0; e < ROB_SIZE; e++) begin : g_entry
        rob_complete_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .flush        (wb_flush),
            .retire       (retire_hit[e]),
            .alloc        (alloc_hit[e]),
            .complete     (comp_hit[e]),
            .payload_in   (comp_pl[e]),
            .allocated    (alloc_q[e]),
            .finished     (fin_q[e]),
            .finished_next(fin_d[e]),
            .payload_next (pl_d[e])
        );
    end

    always_comb begin
        err_d     = err_q;
        next_head = head_id + rob_id_t'($countones(retire_valid));
        cnt_sum   = {1'b0, cnt_q} + cnt_sum_t'($countones(alloc_valid))
                    - cnt_sum_t'($countones(retire_valid));
        if (!wb_flush) begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (ch_acc[i]) begin
                    if (!alloc_q[ch_id[i]] || fin_q[ch_id[i]] || alloc_hit[ch_id[i]]) err_d = 1'b1;
                    for (int j = 0; j < i; j++) begin
                        if (ch_acc[j] && ch_id[j] == ch_id[i]) err_d = 1'b1;
                    end
                end
            end
            for (int a = 0; a < ALLOC_W; a++) begin
                if (alloc_valid[a] && alloc_q[al_id[a]]) err_d = 1'b1;
            end
            for (int k = 0; k < COMMIT_W; k++) begin
                if (retire_valid[k] && !fin_q[head_id + rob_id_t'(k)]) err_d = 1'b1;
                if (k > 0 && retire_valid[k] && !retire_valid[k-1]) err_d = 1'b1;
            end
            // Negative results show up in the extra top bit.
            if (cnt_sum[CntW-1] || cnt_sum > cnt_sum_t'(ROB_SIZE)) err_d = 1'b1;
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_d[k].finished = fin_d[next_head + rob_id_t'(k)];
            slot_d[k].payload  = fin_d[next_head + rob_id_t'(k)] ? pl_d[next_head + rob_id_t'(k)] : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q  <= '0;
            err_q  <= 1'b0;
            slot_q <= '0;
        end else begin
            cnt_q  <= wb_flush ? '0 : cnt_sum[ROB_ID_W:0];
            err_q  <= err_d;
            slot_q <= slot_d;
        end
    end

    always_comb begin
        for (int k = 0; k < COMMIT_W; k++) begin
            slot_finished[k]                          = slot_q[k].finished;
            slot_has_exc[k]                           = slot_q[k].payload.has_exc;
            slot_exc_id[k*EXC_ID_W +: EXC_ID_W]       = slot_q[k].payload.exc_id;
            slot_exc_value[k*DATA_W +: DATA_W]        = slot_q[k].payload.exc_value;
            slot_bru_jump[k]                          = slot_q[k].payload.bru_jump;
            slot_bru_next_pc[k*DATA_W +: DATA_W]      = slot_q[k].payload.bru_next_pc;
        end
    end

    assign inflight_cnt = cnt_q;
    assign proto_err    = err_q;

endmodule

// File: tb/tb_commit_wb_receiver.sv
// Self-checking bench for commit_wb_receiver: directed scenarios plus randomized legal traffic
// checked against a procedural ROB-table model.
module tb_commit_wb_receiver;

    logic         clk = 1'b0;
    logic         rst, wb_we, wb_flush;
    logic [3:0]   wb_enable, wb_valid, wb_has_exc, wb_bru_jump;
    logic [23:0]  wb_rob_id;
    logic [19:0]  wb_exc_id;
    logic [127:0] wb_exc_value, wb_bru_next_pc;
    logic [1:0]   alloc_valid, retire_valid;
    logic [11:0]  alloc_id;
    logic [5:0]   head_id;
    logic [1:0]   slot_finished, slot_has_exc, slot_bru_jump;
    logic [9:0]   slot_exc_id;
    logic [63:0]  slot_exc_value, slot_bru_next_pc;
    logic [6:0]   inflight_cnt;
    logic         proto_err;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit          m_alloc [64];
    bit          m_fin   [64];
    bit          m_exc   [64];
    logic [4:0]  m_eid   [64];
    logic [31:0] m_ev    [64];
    bit          m_j     [64];
    logic [31:0] m_pc    [64];
    bit          m_err;
    int          m_cnt;
    logic [1:0]  e_fin, e_exc, e_j;
    logic [9:0]  e_eid;
    logic [63:0] e_ev, e_pc;

    commit_wb_receiver dut (
        .clk             (clk),
        .rst             (rst),
        .wb_we           (wb_we),
        .wb_flush        (wb_flush),
        .wb_enable       (wb_enable),
        .wb_valid        (wb_valid),
        .wb_rob_id       (wb_rob_id),
        .wb_has_exc      (wb_has_exc),
        .wb_exc_id       (wb_exc_id),
        .wb_exc_value    (wb_exc_value),
        .wb_bru_jump     (wb_bru_jump),
        .wb_bru_next_pc  (wb_bru_next_pc),
        .alloc_valid     (alloc_valid),
        .alloc_id        (alloc_id),
        .head_id         (head_id),
        .retire_valid    (retire_valid),
        .slot_finished   (slot_finished),
        .slot_has_exc    (slot_has_exc),
        .slot_exc_id     (slot_exc_id),
        .slot_exc_value  (slot_exc_value),
        .slot_bru_jump   (slot_bru_jump),
        .slot_bru_next_pc(slot_bru_next_pc),
        .inflight_cnt    (inflight_cnt),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        int first_ch [64];
        bit alloc_now [64];
        int id, c, tmp, h, idx, na, nr;
        na = $countones(alloc_valid);
        nr = $countones(retire_valid);
        for (int e = 0; e < 64; e++) begin
            first_ch[e]  = -1;
            alloc_now[e] = 1'b0;
        end
        if (!rst) begin
            for (int e = 0; e < 64; e++) begin m_alloc[e] = 0; m_fin[e] = 0; end
            m_err = 0;
            m_cnt = 0;
        end else if (wb_flush) begin
            for (int e = 0; e < 64; e++) begin m_alloc[e] = 0; m_fin[e] = 0; end
            m_cnt = 0;
        end else begin
            for (int a = 0; a < 2; a++) begin
                if (alloc_valid[a]) begin
                    id = int'(alloc_id[a*6 +: 6]);
                    if (m_alloc[id]) m_err = 1;
                    alloc_now[id] = 1;
                end
            end
            for (int ch = 0; ch < 4; ch++) begin
                if (wb_we && wb_enable[ch] && wb_valid[ch]) begin
                    id = int'(wb_rob_id[ch*6 +: 6]);
                    if (!m_alloc[id] || m_fin[id] || alloc_now[id] || first_ch[id] >= 0) m_err = 1;
                    if (first_ch[id] < 0) first_ch[id] = ch;
                end
            end
            if (retire_valid[1] && !retire_valid[0]) m_err = 1;
            for (int k = 0; k < 2; k++) begin
                if (retire_valid[k] && !m_fin[(int'(head_id) + k) % 64]) m_err = 1;
            end
            tmp = m_cnt + na - nr;
            if (tmp < 0 || tmp > 64) m_err = 1;
            m_cnt = tmp & 127;
            for (int e = 0; e < 64; e++) begin
                if (first_ch[e] >= 0 && m_alloc[e]) begin
                    c        = first_ch[e];
                    m_fin[e] = 1;
                    m_exc[e] = wb_has_exc[c];
                    m_eid[e] = wb_exc_id[c*5 +: 5];
                    m_ev[e]  = wb_exc_value[c*32 +: 32];
                    m_j[e]   = wb_bru_jump[c];
                    m_pc[e]  = wb_bru_next_pc[c*32 +: 32];
                end
            end
            for (int e = 0; e < 64; e++) begin
                if (alloc_now[e]) begin m_alloc[e] = 1; m_fin[e] = 0; end
            end
            for (int k = 0; k < 2; k++) begin
                if (retire_valid[k]) begin
                    idx = (int'(head_id) + k) % 64;
                    m_alloc[idx] = 0;
                    m_fin[idx]   = 0;
                end
            end
        end
        h = (int'(head_id) + nr) % 64;
        e_fin = '0; e_exc = '0; e_j = '0; e_eid = '0; e_ev = '0; e_pc = '0;
        for (int k = 0; k < 2; k++) begin
            idx = (h + k) % 64;
            if (m_fin[idx]) begin
                e_fin[k]         = 1'b1;
                e_exc[k]         = m_exc[idx];
                e_eid[k*5 +: 5]  = m_eid[idx];
                e_ev[k*32 +: 32] = m_ev[idx];
                e_j[k]           = m_j[idx];
                e_pc[k*32 +: 32] = m_pc[idx];
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_we = 0; wb_flush = 0; wb_enable = '0; wb_valid = '0; wb_rob_id = '0;
        wb_has_exc = '0; wb_exc_id = '0; wb_exc_value = '0; wb_bru_jump = '0;
        wb_bru_next_pc = '0; alloc_valid = '0; alloc_id = '0; retire_valid = '0;
    endtask

    task automatic set_ch(input int c, input int id, input bit exc, input int eid,
                          input logic [31:0] ev, input bit j, input logic [31:0] pc);
        wb_we                     = 1'b1;
        wb_enable[c]              = 1'b1;
        wb_valid[c]               = 1'b1;
        wb_rob_id[c*6 +: 6]       = 6'(id);
        wb_has_exc[c]             = exc;
        wb_exc_id[c*5 +: 5]       = 5'(eid);
        wb_exc_value[c*32 +: 32]  = ev;
        wb_bru_jump[c]            = j;
        wb_bru_next_pc[c*32 +: 32] = pc;
    endtask

    task automatic reset_pulse();
        idle();
        rst = 1'b0;
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            wb_we = 1'($urandom); wb_flush = 1'($urandom);
            wb_enable = 4'($urandom); wb_valid = 4'($urandom); wb_rob_id = 24'($urandom);
            wb_has_exc = 4'($urandom); wb_exc_id = 20'($urandom);
            wb_exc_value = {$urandom, $urandom, $urandom, $urandom};
            wb_bru_jump = 4'($urandom);
            wb_bru_next_pc = {$urandom, $urandom, $urandom, $urandom};
            alloc_valid = 2'($urandom); alloc_id = 12'($urandom);
            head_id = 6'($urandom); retire_valid = 2'($urandom);
            tick();
        end
        n_checks++;
        if ({slot_finished, slot_has_exc, slot_exc_id, slot_exc_value, slot_bru_jump,
             slot_bru_next_pc, proto_err} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got fin=%b exc=%b err=%b, want all zero",
                     slot_finished, slot_has_exc, proto_err);
        end
        n_checks++;
        if (inflight_cnt !== 7'd0) begin
            n_errors++;
            $display("FAIL reset_cnt: got %0d want 0", inflight_cnt);
        end
        rst = 1'b1;
        idle();
    endtask

    task automatic test_latency();
        idle(); head_id = 6'd5; alloc_valid = 2'b01; alloc_id[5:0] = 6'd5;
        tick();
        n_checks++;
        if (slot_finished[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_before: slot_finished[0] got %b want 0", slot_finished[0]);
        end
        idle(); head_id = 6'd5; set_ch(2, 5, 0, 0, 32'h0, 1, 32'h8000_0040);
        tick();
        n_checks++;
        if (slot_finished[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL lat_after: slot_finished[0] got %b want 1", slot_finished[0]);
        end
        n_checks++;
        if (slot_bru_jump[0] !== 1'b1 || slot_bru_next_pc[31:0] !== 32'h8000_0040) begin
            n_errors++;
            $display("FAIL lat_bru: got jump=%b pc=%h want 1 80000040",
                     slot_bru_jump[0], slot_bru_next_pc[31:0]);
        end
        idle(); head_id = 6'd5; retire_valid = 2'b01;
        tick();
        n_checks++;
        if (inflight_cnt !== 7'd0 || proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL lat_retire: got cnt=%0d err=%b want 0 0", inflight_cnt, proto_err);
        end
    endtask

    task automatic test_wrap();
        idle(); head_id = 6'd63; alloc_valid = 2'b11; alloc_id = {6'd0, 6'd63};
        tick();
        idle(); head_id = 6'd63;
        set_ch(0, 63, 0, 0, 32'h0, 0, 32'h1234_5678);
        set_ch(1, 0, 1, 2, 32'hDEAD_0001, 0, 32'h0);
        tick();
        n_checks++;
        if (slot_finished !== 2'b11 || slot_has_exc !== 2'b10) begin
            n_errors++;
            $display("FAIL wrap_flags: got fin=%b exc=%b want 11 10", slot_finished, slot_has_exc);
        end
        n_checks++;
        if (slot_exc_id[9:5] !== 5'd2 || slot_exc_value[63:32] !== 32'hDEAD_0001) begin
            n_errors++;
            $display("FAIL wrap_exc: got id=%0d val=%h want 2 dead0001",
                     slot_exc_id[9:5], slot_exc_value[63:32]);
        end
        idle(); head_id = 6'd63; retire_valid = 2'b11;
        tick();
        n_checks++;
        if (inflight_cnt !== 7'd0 || slot_finished !== 2'b00 || proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_retire2: got cnt=%0d fin=%b err=%b want 0 00 0",
                     inflight_cnt, slot_finished, proto_err);
        end
    endtask

    task automatic test_flush();
        for (int c = 0; c < 5; c++) begin
            idle(); head_id = 6'd1; alloc_valid = 2'b11;
            alloc_id = {6'(2*c + 2), 6'(2*c + 1)};
            tick();
        end
        idle(); head_id = 6'd1;
        for (int c = 0; c < 4; c++) set_ch(c, c + 1, 0, 0, $urandom, 1, $urandom);
        tick();
        n_checks++;
        if (slot_finished !== 2'b11 || inflight_cnt !== 7'd10) begin
            n_errors++;
            $display("FAIL flush_pre: got fin=%b cnt=%0d want 11 10", slot_finished, inflight_cnt);
        end
        idle(); head_id = 6'd1; wb_flush = 1'b1;
        set_ch(0, 5, 0, 0, 32'h0, 0, 32'h0);
        set_ch(1, 6, 1, 3, 32'h0, 0, 32'h0);
        alloc_valid = 2'b11; alloc_id = {6'd12, 6'd11}; retire_valid = 2'b01;
        tick();
        n_checks++;
        if (inflight_cnt !== 7'd0 || slot_finished !== 2'b00 || proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL flush: got cnt=%0d fin=%b err=%b want 0 00 0",
                     inflight_cnt, slot_finished, proto_err);
        end
        idle(); head_id = 6'd5;
        tick();
        n_checks++;
        if (slot_finished !== 2'b00) begin
            n_errors++;
            $display("FAIL flush_table: got fin=%b want 00", slot_finished);
        end
    endtask

    task automatic test_proto_err();
        reset_pulse();
        idle(); head_id = 6'd9; alloc_valid = 2'b01; alloc_id[5:0] = 6'd9;
        tick();
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_clean: got %b want 0", proto_err);
        end
        idle(); head_id = 6'd9;
        set_ch(0, 9, 0, 0, 32'h0, 1, 32'hA000_0000);
        set_ch(3, 9, 1, 7, 32'h0, 0, 32'hB000_0000);
        tick();
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_dup: got %b want 1", proto_err);
        end
        n_checks++;
        if (slot_bru_next_pc[31:0] !== 32'hA000_0000 || slot_has_exc[0] !== 1'b0) begin
            n_errors++;
            $display("FAIL dup_winner: got pc=%h exc=%b want a0000000 0",
                     slot_bru_next_pc[31:0], slot_has_exc[0]);
        end
        reset_pulse();
        n_checks++;
        if (proto_err !== 1'b0) begin
            n_errors++;
            $display("FAIL err_reset: got %b want 0", proto_err);
        end
        idle(); set_ch(1, 7, 0, 0, 32'h0, 0, 32'h0);
        tick();
        for (int c = 0; c < 3; c++) begin idle(); tick(); end
        n_checks++;
        if (proto_err !== 1'b1) begin
            n_errors++;
            $display("FAIL err_unalloc_sticky: got %b want 1", proto_err);
        end
        reset_pulse();
    endtask

    task automatic test_random();
        int hd, tail, nr, off, id;
        bit picked [64];
        reset_pulse();
        hd = 0; tail = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            idle();
            for (int e = 0; e < 64; e++) picked[e] = 0;
            head_id = 6'(hd);
            if (m_fin[hd] && $urandom_range(1, 0) == 1) begin
                retire_valid[0] = 1'b1;
                if (m_fin[(hd + 1) % 64] && $urandom_range(1, 0) == 1) retire_valid[1] = 1'b1;
            end
            for (int a = 0; a < 2; a++) begin
                if (m_cnt + int'($countones(alloc_valid)) < 60 && $urandom_range(2, 0) != 0) begin
                    alloc_valid[a]      = 1'b1;
                    alloc_id[a*6 +: 6]  = 6'(tail);
                    tail                = (tail + 1) % 64;
                end
            end
            wb_we = ($urandom_range(7, 0) != 0);
            for (int c = 0; c < 4; c++) begin
                if (m_cnt > 0 && $urandom_range(2, 0) != 0) begin
                    off = int'($urandom_range(m_cnt - 1, 0));
                    id  = (hd + off) % 64;
                    if (m_alloc[id] && !m_fin[id] && !picked[id]) begin
                        picked[id] = 1;
                        set_ch(c, id, 1'($urandom), int'($urandom_range(31, 0)), $urandom,
                               1'($urandom), $urandom);
                        wb_we = 1'b1;
                    end
                end else if ($urandom_range(3, 0) == 0) begin
                    wb_enable[c]        = 1'b1;
                    wb_rob_id[c*6 +: 6] = 6'($urandom);
                    wb_bru_next_pc[c*32 +: 32] = $urandom;
                end
            end
            if ($urandom_range(40, 0) == 0) wb_flush = 1'b1;
            nr = $countones(retire_valid);
            tick();
            hd = wb_flush ? tail : (hd + nr) % 64;
            n_checks++;
            if ({slot_finished, slot_has_exc, slot_exc_id, slot_exc_value, slot_bru_jump,
                 slot_bru_next_pc} !== {e_fin, e_exc, e_eid, e_ev, e_j, e_pc}) begin
                n_errors++;
                $display("FAIL rand_slots cyc %0d: got fin=%b exc=%b id=%h ev=%h j=%b pc=%h want fin=%b exc=%b id=%h ev=%h j=%b pc=%h",
                         cyc, slot_finished, slot_has_exc, slot_exc_id, slot_exc_value,
                         slot_bru_jump, slot_bru_next_pc, e_fin, e_exc, e_eid, e_ev, e_j, e_pc);
            end
            n_checks++;
            if (inflight_cnt !== 7'(m_cnt) || proto_err !== m_err) begin
                n_errors++;
                $display("FAIL rand_cnt_err cyc %0d: got cnt=%0d err=%b want cnt=%0d err=%b",
                         cyc, inflight_cnt, proto_err, m_cnt, m_err);
            end
        end
    endtask

    initial begin
        idle();
        head_id = '0;
        rst     = 1'b0;
        test_reset();
        test_latency();
        test_wrap();
        test_flush();
        test_proto_err();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
